// File: rtl/uart_tx.sv
// uart_tx: UART transmitter, 8N1 frames (8E1 when UART_TX_PARITY_EN is defined), LSB first.
// A one-byte holding register lets the next byte queue during the current frame, so
// back-to-back frames go out with no idle gap.
//
// Optional feature macro: UART_TX_PARITY_EN adds an even-parity bit between data bit 7
// and the stop bit.
//
// Ports:
//   clk       system clock
//   rst_n     asynchronous reset, active low
//   tx_data   byte to send, sampled only on an accept cycle
//   tx_valid  tx_data is valid
//   tx_ready  holding register empty; accept on rising edge with tx_valid && tx_ready
//   tx        UART line, idle high
//   tx_busy   a frame is on the line
//   tx_done   one-cycle pulse at the end of each stop bit
module uart_tx #(
  parameter int unsigned CLK_FREQ  = 100_000_000,
  parameter int unsigned BAUD_RATE = 115200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int unsigned BAUD_DIV = CLK_FREQ / BAUD_RATE;
  localparam logic [15:0] BaudLast = 16'(BAUD_DIV - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
`ifdef UART_TX_PARITY_EN
    StParity,
`endif
    StStop
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] baud_cnt_q, baud_cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  hold_q, hold_d;
  logic        hold_full_q, hold_full_d;
  logic        tx_q, tx_d;
  logic        done_q, done_d;
`ifdef UART_TX_PARITY_EN
  logic        parity_q, parity_d;
`endif

  logic bit_end;
  logic load;

  assign bit_end  = (baud_cnt_q == BaudLast);
  assign tx_ready = ~hold_full_q;
  assign tx       = tx_q;
  assign tx_busy  = (state_q != StIdle);
  assign tx_done  = done_q;

  always_comb begin
    state_d     = state_q;
    baud_cnt_d  = bit_end ? 16'd0 : baud_cnt_q + 16'd1;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    tx_d        = tx_q;
    done_d      = 1'b0;
    load        = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d    = parity_q;
`endif

    // Accept and drain are mutually exclusive: accept needs the register empty.
    if (tx_valid && !hold_full_q) begin
      hold_d      = tx_data;
      hold_full_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        baud_cnt_d = 16'd0;
        tx_d       = 1'b1;
        load       = hold_full_q;
      end
      StStart: begin
        if (bit_end) begin
          tx_d      = shift_q[0];
          bit_idx_d = 3'd0;
          state_d   = StData;
        end
      end
      StData: begin
        if (bit_end) begin
          if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            tx_d    = parity_q;
            state_d = StParity;
`else
            tx_d    = 1'b1;
            state_d = StStop;
`endif
          end else begin
            shift_d   = {1'b0, shift_q[7:1]};
            tx_d      = shift_q[1];
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      StParity: begin
        if (bit_end) begin
          tx_d    = 1'b1;
          state_d = StStop;
        end
      end
`endif
      StStop: begin
        if (bit_end) begin
          done_d = 1'b1;
          if (hold_full_q) begin
            load = 1'b1;
          end else begin
            tx_d    = 1'b1;
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Drain the holding register into the shifter and open a start bit.
    if (load) begin
      shift_d     = hold_q;
      hold_full_d = 1'b0;
      tx_d        = 1'b0;
      baud_cnt_d  = 16'd0;
      state_d     = StStart;
`ifdef UART_TX_PARITY_EN
      parity_d    = ^hold_q;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      baud_cnt_q  <= 16'd0;
      bit_idx_q   <= 3'd0;
      shift_q     <= 8'd0;
      hold_q      <= 8'd0;
      hold_full_q <= 1'b0;
      tx_q        <= 1'b1;
      done_q      <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      baud_cnt_q  <= baud_cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      tx_q        <= tx_d;
      done_q      <= done_d;
`ifdef UART_TX_PARITY_EN
      parity_q    <= parity_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Testbench for uart_tx: randomized and directed bytes; a line monitor decodes every cycle
// of each frame against the expected byte popped from a scoreboard queue.
module tb_uart_tx;

  localparam int DIV = 10;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = NBITS * DIV;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, tx, tx_busy, tx_done;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  logic [7:0] exp_q[$];
  int         starts[$];

  uart_tx #(
    .CLK_FREQ (1_000_000),
    .BAUD_RATE(100_000)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .tx      (tx),
    .tx_busy (tx_busy),
    .tx_done (tx_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Expected line bits of a frame, index 0 = start bit.
  function automatic logic [NBITS-1:0] frame_of(input logic [7:0] b);
`ifdef UART_TX_PARITY_EN
    return {1'b1, ^b, b, 1'b0};
`else
    return {1'b1, b, 1'b0};
`endif
  endfunction

  // Line monitor: one sample per cycle at the falling edge.
  logic             active = 1'b0;
  logic             finishing = 1'b0;
  int               pos = 0;
  logic [NBITS-1:0] bits = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      active    = 1'b0;
      finishing = 1'b0;
      exp_q.delete();
      chk("rst_tx", tx, 1'b1);
      chk("rst_busy", tx_busy, 1'b0);
      chk("rst_ready", tx_ready, 1'b1);
      chk("rst_done", tx_done, 1'b0);
    end else begin
      chk("tx_done", tx_done, finishing);
      finishing = 1'b0;
      if (!active && tx === 1'b0) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_frame", 32'd1, 32'd0);
        end else begin
          bits   = frame_of(exp_q.pop_front());
          active = 1'b1;
          pos    = 0;
          starts.push_back(cyc);
        end
      end
      chk("tx_busy", tx_busy, active);
      if (active) begin
        chk("tx_bit", tx, bits[pos/DIV]);
        pos++;
        if (pos == FRAME) begin
          active    = 1'b0;
          finishing = 1'b1;
        end
      end else begin
        chk("idle_tx", tx, 1'b1);
      end
    end
  end

  int last_accept = 0;

  // Present a byte at a falling edge and hold it until accepted (bounded).
  task automatic send(input logic [7:0] b);
    int waited = 0;
    tx_data  = b;
    tx_valid = 1'b1;
    while (!tx_ready && waited < 4 * FRAME) begin
      @(negedge clk);
      waited++;
    end
    if (!tx_ready) begin
      chk("accept_timeout", 32'd1, 32'd0);
    end else begin
      exp_q.push_back(b);
      last_accept = cyc;
      @(negedge clk);
      chk("ready_after_accept", tx_ready, 1'b0);
    end
    tx_valid = 1'b0;
    tx_data  = 8'($urandom);
  endtask

  task automatic wait_idle();
    int waited = 0;
    while (!(tx_ready && !tx_busy && !active && exp_q.size() == 0) && waited < 30 * FRAME) begin
      @(negedge clk);
      tx_data = 8'($urandom);
      waited++;
    end
    chk("idle_timeout", (waited < 30 * FRAME) ? 32'd1 : 32'd0, 32'd1);
    @(negedge clk);
  endtask

  initial begin
    // 1: reset values, then a quiet idle line.
    #12;
    chk("init_tx", tx, 1'b1);
    chk("init_ready", tx_ready, 1'b1);
    chk("init_busy", tx_busy, 1'b0);
    chk("init_done", tx_done, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (50) @(negedge clk);

    // 2: single byte from idle; start bit two samples after the accept sample.
    starts.delete();
    send(8'hA5);
    wait_idle();
    chk("a5_frames", starts.size(), 1);
    if (starts.size() == 1) chk("a5_latency", starts[0] - last_accept, 2);

    // 3: back-to-back with zero idle gap.
    starts.delete();
    send(8'h00);
    send(8'hFF);
    wait_idle();
    chk("b2b_frames", starts.size(), 2);
    if (starts.size() == 2) chk("b2b_gap", starts[1] - starts[0], FRAME);

    // 4: third byte held valid while the holding register is full.
    starts.delete();
    send(8'h81);
    send(8'h42);
    send(8'h3C);
    wait_idle();
    chk("hold_frames", starts.size(), 3);

    // 5: reset during data bit 4 aborts the frame.
    send(8'hFF);
    begin
      int w = 0;
      while (!tx_busy && w < 10) begin
        @(negedge clk);
        w++;
      end
    end
    repeat (5 * DIV + 3) @(negedge clk);
    chk("pre_rst_tx", tx, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_tx", tx, 1'b1);
    chk("async_busy", tx_busy, 1'b0);
    chk("async_ready", tx_ready, 1'b1);
    chk("async_done", tx_done, 1'b0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    starts.delete();
    send(8'h12);
    wait_idle();
    chk("post_rst_frames", starts.size(), 1);

`ifdef UART_TX_PARITY_EN
    // 6: parity directed cases.
    send(8'h07);
    wait_idle();
    send(8'h03);
    wait_idle();
`endif

    // Randomized traffic with random gaps.
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        int g = $urandom_range(1, 150);
        for (int k = 0; k < g; k++) begin
          @(negedge clk);
          tx_data = 8'($urandom);
        end
      end
      send(8'($urandom));
    end
    wait_idle();
    chk("queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
